rr_arb4: RTL and testbench

- Round-robin arbiter for four requesters that share one 4:1 data mux.
- Drives that mux's 2-bit select and runs a valid/ready handshake toward the downstream consumer.
- Each grant is held for a burst of up to BURST beats, then priority rotates.
- Sits directly upstream of the 4:1 mux and controls it; the mux data path stays purely combinational.

---
 rtl/rr_arb4.sv | 109 ++++++++++
 tb/tb_rr_arb4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// rr_arb4: four-channel round-robin arbiter driving a shared 4:1 mux select.
// A grant is held for up to BURST beats, then priority rotates past the
// granted channel. Each grant is followed by one IDLE bubble cycle.
module rr_arb4 #(
  parameter int BURST = 4,
  parameter int CW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] select,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic [3:0] in_ready,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sel, sel_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          fire;
  logic          last_beat;
  logic [1:0]    pick;
  logic          pick_ok;

  // Output decode; select follows sel in both states.
  always_comb begin
    select    = sel;
    gnt       = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (state == GRANT) begin
      gnt[sel]  = 1'b1;
      out_valid = req[sel];
      busy      = 1'b1;
    end
    in_ready  = gnt & {4{out_ready}};
    fire      = out_valid & out_ready;
    last_beat = (cnt == CW'(BURST - 1));
  end

  // Priority scan starting at ptr, wrapping modulo 4.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      logic [1:0] idx;
      idx = ptr + 2'(i);
      if (!pick_ok && req[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  // Next-state logic: grant from IDLE, burst counting and release in GRANT.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          sel_n   = pick;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel] || (fire && last_beat)) begin
          state_n = IDLE;
          ptr_n   = sel + 2'd1;
          cnt_n   = '0;
        end else if (fire) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed vectors with hand-computed expectations for rr_arb4.
module tb_rr_arb4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] select;
  logic [3:0] gnt;
  logic       out_valid;
  logic [3:0] in_ready;
  logic       busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  rr_arb4 #(.BURST(4), .CW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .select    (select),
    .gnt       (gnt),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int unsigned ch);
    logic [3:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  initial begin
    int unsigned ch;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;

    // Reset state with all channels requesting
    #12;
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Rotation: 0,1,2,3,0 each with 4 beats and one bubble
    for (int g = 0; g < 5; g++) begin
      ch = 32'(g % 4);
      if (g > 0) tick();
      for (int b = 0; b < 4; b++) begin
        chk("rot_select", 32'(select), 32'(ch));
        chk("rot_gnt", 32'(gnt), 32'(oh(ch)));
        chk("rot_inrdy", 32'(in_ready), 32'(oh(ch)));
        chk("rot_busy", 32'(busy), 32'd1);
        tick();
      end
      chk("rot_bubble_gnt", 32'(gnt), 32'd0);
      chk("rot_bubble_busy", 32'(busy), 32'd0);
      chk("rot_bubble_valid", 32'(out_valid), 32'd0);
    end

    // Backpressure on channel 2 (ptr=1 now)
    req = 4'b0100;
    out_ready = 1'b0;
    tick();
    for (int b = 0; b < 5; b++) begin
      chk("bp_select", 32'(select), 32'd2);
      chk("bp_gnt", 32'(gnt), 32'b0100);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_inrdy", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) begin
      chk("bp_beat_inrdy", 32'(in_ready), 32'b0100);
      tick();
    end
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_select", 32'(select), 32'd2);

    // ptr=3: req 1001 must pick channel 3
    req = 4'b1001;
    tick();
    chk("wrap_gnt3", 32'(gnt), 32'b1000);
    chk("wrap_select3", 32'(select), 32'd3);
    for (int b = 0; b < 4; b++) tick();
    chk("wrap_release_busy", 32'(busy), 32'd0);
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'b0001);
    for (int b = 0; b < 4; b++) tick();
    chk("wrap2_release_busy", 32'(busy), 32'd0);

    // Early drop on channel 1 after two beats (ptr=1 now)
    req = 4'b0011;
    tick();
    chk("drop_gnt1", 32'(gnt), 32'b0010);
    chk("drop_beat0", 32'(in_ready), 32'b0010);
    tick();
    chk("drop_beat1", 32'(in_ready), 32'b0010);
    tick();
    req = 4'b0001;
    #1;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("drop_gnt_held", 32'(gnt), 32'b0010);
    tick();
    chk("drop_release_busy", 32'(busy), 32'd0);
    req = 4'b0011;
    tick();
    chk("drop_next_gnt0", 32'(gnt), 32'b0001);

    // Async reset mid-burst (cnt=2, ptr=2)
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_inrdy", 32'(in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_select", 32'(select), 32'd0);
    req = 4'b0101;
    tick();
    chk("arst_hold_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_next_gnt0", 32'(gnt), 32'b0001);
    chk("arst_next_select", 32'(select), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
